// File: rtl/ines_pkg.sv
// ines_pkg
// Shared constants and types for the iNES stream loader: header magic,
// bank/trainer sizes, FSM state encoding and error codes.
package ines_pkg;

    localparam logic [31:0] INES_MAGIC    = 32'h4E45_531A;
    localparam int unsigned PRG_BANK_SIZE = 16384;
    localparam int unsigned CHR_BANK_SIZE = 8192;
    localparam int unsigned TRAINER_LEN   = 512;
    localparam int          CNT_W         = 22;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_TRAINER = 3'd2,
        ST_PRG     = 3'd3,
        ST_CHR     = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MAGIC = 2'd1;
    localparam logic [1:0] ERR_SIZE  = 2'd2;
    localparam logic [1:0] ERR_SHORT = 2'd3;

    // Expected value of header byte 0..3.
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INES_MAGIC[31:24];
            2'd1:    b = INES_MAGIC[23:16];
            2'd2:    b = INES_MAGIC[15:8];
            default: b = INES_MAGIC[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ines_stream_loader.sv
// ines_stream_loader
// Consumes an iNES file as a byte/strobe stream, checks the header, skips an
// optional trainer and writes PRG then CHR bytes into the cartridge map.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   downloading           high while a file streams; rising edge starts a load
//   in_data, in_strobe    stream byte and its single-cycle strobe
//   mem_addr/data/write   one write pulse per PRG/CHR byte, 1 cycle after strobe
//   mapper_flags          {flags7, flags6, chr_banks, prg_banks}
//   busy, done, error     load status (done/error held until the next load)
//   err_code              1 bad magic, 2 bad size, 3 short file
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the first rising edge of downloading
// HEADER  | receiving header bytes 0..15
// TRAINER | discarding the 512-byte trainer
// PRG     | writing PRG bytes from address 0
// CHR     | writing CHR bytes from CHR_BASE
// DONE    | load complete; trailing bytes dropped
// ERROR   | load aborted; err_code holds the reason
module ines_stream_loader
    import ines_pkg::*;
#(
    parameter int                 ADDR_W        = 22,
    parameter logic [ADDR_W-1:0]  CHR_BASE      = 22'h200000,
    parameter int                 MAX_PRG_BANKS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              downloading,
    input  logic [7:0]        in_data,
    input  logic              in_strobe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_write,
    output logic [31:0]       mapper_flags,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    state_e             state_q, state_d;
    logic               dl_q;
    logic [3:0]         hdr_idx_q, hdr_idx_d;
    logic [7:0]         prg_q, prg_d;
    logic [7:0]         chr_q, chr_d;
    logic [7:0]         f6_q, f6_d;
    logic [7:0]         f7_q, f7_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;

    logic dl_rise, dl_fall, byte_v;
    logic [CNT_W-1:0] prg_len, chr_len;

    assign dl_rise = downloading & ~dl_q;
    assign dl_fall = ~downloading & dl_q;
    // A byte arriving in the same cycle downloading falls still belongs to
    // the file, so the previous-cycle level also qualifies the strobe.
    assign byte_v  = in_strobe & (downloading | dl_q);

    assign prg_len = CNT_W'(prg_q) * CNT_W'(PRG_BANK_SIZE);
    assign chr_len = CNT_W'(chr_q) * CNT_W'(CHR_BANK_SIZE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            // Starts high so a downloading level held across reset is not
            // mistaken for a new rising edge.
            dl_q      <= 1'b1;
            hdr_idx_q <= '0;
            prg_q     <= '0;
            chr_q     <= '0;
            f6_q      <= '0;
            f7_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= ERR_NONE;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            dl_q      <= downloading;
            hdr_idx_q <= hdr_idx_d;
            prg_q     <= prg_d;
            chr_q     <= chr_d;
            f6_q      <= f6_d;
            f7_q      <= f7_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        prg_d     = prg_q;
        chr_d     = chr_q;
        f6_d      = f6_q;
        f7_d      = f7_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (dl_rise) begin
                    state_d   = ST_HEADER;
                    err_d     = ERR_NONE;
                    hdr_idx_d = '0;
                end
            end

            ST_HEADER: begin
                if (byte_v) begin
                    hdr_idx_d = hdr_idx_q + 4'd1;
                    case (hdr_idx_q)
                        4'd4:    prg_d = in_data;
                        4'd5:    chr_d = in_data;
                        4'd6:    f6_d  = in_data;
                        4'd7:    f7_d  = in_data;
                        default: ;
                    endcase
                    if (hdr_idx_q < 4'd4 && in_data != magic_byte(hdr_idx_q[1:0])) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_MAGIC;
                    end else if (hdr_idx_q == 4'd15) begin
                        if (prg_q == 8'd0 || int'(prg_q) > MAX_PRG_BANKS) begin
                            state_d = ST_ERROR;
                            err_d   = ERR_SIZE;
                        end else if (f6_q[2]) begin
                            state_d = ST_TRAINER;
                            cnt_d   = CNT_W'(TRAINER_LEN);
                        end else begin
                            state_d = ST_PRG;
                            cnt_d   = prg_len;
                            addr_d  = '0;
                        end
                    end
                end
            end

            ST_TRAINER: begin
                if (byte_v) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_PRG;
                        cnt_d   = prg_len;
                        addr_d  = '0;
                    end
                end
            end

            ST_PRG, ST_CHR: begin
                if (byte_v) begin
                    wr_d      = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    addr_d    = addr_q + ADDR_W'(1);
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (state_q == ST_PRG && chr_q != 8'd0) begin
                            state_d = ST_CHR;
                            addr_d  = CHR_BASE;
                            cnt_d   = chr_len;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Losing downloading mid-load aborts unless the same cycle's byte
        // finished the file; a partially accepted byte is not written.
        if (dl_fall && (state_q == ST_HEADER || state_q == ST_TRAINER ||
                        state_q == ST_PRG    || state_q == ST_CHR) &&
            state_d != ST_DONE && state_d != ST_ERROR) begin
            state_d = ST_ERROR;
            err_d   = ERR_SHORT;
            wr_d    = 1'b0;
        end
    end

    assign mem_write    = wr_q;
    assign mem_addr     = wr_addr_q;
    assign mem_data     = wr_data_q;
    assign mapper_flags = {f7_q, f6_q, chr_q, prg_q};
    assign busy         = (state_q == ST_HEADER) || (state_q == ST_TRAINER) ||
                          (state_q == ST_PRG)    || (state_q == ST_CHR);
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign err_code     = err_q;

endmodule

// File: tb/tb_ines_stream_loader.sv
// tb_ines_stream_loader
// Scoreboard bench: each streamed PRG/CHR byte pushes its expected write;
// a negedge monitor pops and compares every mem_write pulse.
module tb_ines_stream_loader;

    localparam logic [21:0] CHR_BASE = 22'h200000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        downloading = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_strobe = 1'b0;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;
    logic [31:0] mapper_flags;
    logic        busy, done, error;
    logic [1:0]  err_code;

    ines_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .downloading  (downloading),
        .in_data      (in_data),
        .in_strobe    (in_strobe),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_write    (mem_write),
        .mapper_flags (mapper_flags),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;
    int  wr_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_write", 64'(mem_addr), 64'h3FFFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                chk("wr_data", 64'(mem_data), 64'(mon_e.data));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobed byte followed by one idle cycle; the write (if any) must be
    // visible right after the edge that samples the strobe.
    task automatic send_byte(input logic [7:0] b, input bit exp_wr,
                             input logic [21:0] a, input bit drop);
        if (exp_wr) exp_q.push_back('{addr: a, data: b});
        @(posedge clk);
        #1;
        in_data   = b;
        in_strobe = 1'b1;
        if (drop) downloading = 1'b0;
        @(posedge clk);
        #1;
        in_strobe = 1'b0;
        chk("wr_latency", 64'(mem_write), 64'(exp_wr));
    endtask

    task automatic start_load();
        @(posedge clk);
        #1;
        downloading = 1'b1;
        cyc(1);
        chk("busy_at_start", 64'(busy), 64'd1);
        chk("err_cleared", 64'({error, err_code}), 64'd0);
    endtask

    task automatic stop_load();
        downloading = 1'b0;
        cyc(2);
    endtask

    task automatic send_header(input logic [7:0] prg, input logic [7:0] chr,
                               input logic [7:0] f6, input logic [7:0] m3);
        logic [7:0] h [16];
        for (int i = 0; i < 16; i++) h[i] = 8'h00;
        h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = m3;
        h[4] = prg;   h[5] = chr;   h[6] = f6;
        for (int i = 0; i < 16; i++) send_byte(h[i], 1'b0, 22'd0, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_outputs", 64'({mem_write, busy, done, error, err_code}), 64'd0);
        chk("rst_flags", 64'(mapper_flags), 64'd0);
        chk("rst_mem", 64'({mem_addr, mem_data}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);

        // Reset in the middle of CHR.
        start_load();
        send_header(8'd1, 8'd1, 8'h00, 8'h1A);
        for (int i = 0; i < 16384; i++) send_byte(8'($urandom), 1'b1, 22'(i), 1'b0);
        chk("in_chr_busy", 64'({busy, done}), 64'b10);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom), 1'b1, CHR_BASE + 22'(i), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_wr", 64'(mem_write), 64'd0);
        chk("async_rst_stat", 64'({busy, done, error, err_code}), 64'd0);
        chk("async_rst_flags", 64'(mapper_flags), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1);
        for (int i = 0; i < 3; i++) send_byte(8'hAA, 1'b0, 22'd0, 1'b0);
        chk("no_restart_wo_edge", 64'({busy, done, error}), 64'd0);
        stop_load();

        // Full PRG + CHR load.
        wr_cnt = 0;
        start_load();
        send_header(8'd1, 8'd1, 8'h00, 8'h1A);
        chk("flags_basic", 64'(mapper_flags), 64'h0000_0101);
        for (int i = 0; i < 16384; i++) send_byte(8'($urandom), 1'b1, 22'(i), 1'b0);
        for (int i = 0; i < 8192; i++) begin
            if (i == 8191) chk("pre_last_done", 64'(done), 64'd0);
            send_byte(8'($urandom), 1'b1, CHR_BASE + 22'(i), 1'b0);
        end
        chk("full_done", 64'({busy, done, error}), 64'b010);
        send_byte(8'h77, 1'b0, 22'd0, 1'b0);
        cyc(1);
        chk("full_wr_cnt", 64'(wr_cnt), 64'd24576);
        chk("full_pending", 64'(exp_q.size()), 64'd0);
        stop_load();
        chk("done_sticky", 64'(done), 64'd1);

        // Bad magic on byte 3.
        wr_cnt = 0;
        start_load();
        send_byte(8'h4E, 1'b0, 22'd0, 1'b0);
        send_byte(8'h45, 1'b0, 22'd0, 1'b0);
        send_byte(8'h53, 1'b0, 22'd0, 1'b0);
        chk("magic_ok_so_far", 64'(error), 64'd0);
        send_byte(8'h1B, 1'b0, 22'd0, 1'b0);
        chk("magic_err", 64'({busy, error, err_code}), 64'b0101);
        for (int i = 0; i < 30; i++) send_byte(8'h01, 1'b0, 22'd0, 1'b0);
        cyc(1);
        chk("magic_no_writes", 64'(wr_cnt), 64'd0);
        stop_load();

        // prg_banks = 0 and 129 rejected, 128 accepted.
        start_load();
        send_header(8'd0, 8'd1, 8'h00, 8'h1A);
        chk("size0_err", 64'({error, err_code}), 64'b110);
        stop_load();
        start_load();
        send_header(8'd129, 8'd1, 8'h00, 8'h1A);
        chk("size129_err", 64'({error, err_code}), 64'b110);
        chk("size129_flags", 64'(mapper_flags), 64'h0000_0181);
        stop_load();
        start_load();
        send_header(8'd128, 8'd0, 8'h00, 8'h1A);
        chk("size128_ok", 64'({busy, error}), 64'b10);
        stop_load();
        chk("short_in_prg", 64'({error, err_code}), 64'b111);

        // Trainer skipped; final byte coincides with the falling edge.
        wr_cnt = 0;
        start_load();
        send_header(8'd1, 8'd0, 8'h04, 8'h1A);
        chk("flags_trainer", 64'(mapper_flags), 64'h0004_0001);
        for (int i = 0; i < 512; i++) send_byte(8'($urandom), 1'b0, 22'd0, 1'b0);
        for (int i = 0; i < 16383; i++) send_byte(8'($urandom), 1'b1, 22'(i), 1'b0);
        chk("trainer_not_done", 64'(done), 64'd0);
        send_byte(8'hC3, 1'b1, 22'd16383, 1'b1);
        chk("trainer_done", 64'({busy, done, error}), 64'b010);
        cyc(1);
        chk("trainer_wr_cnt", 64'(wr_cnt), 64'd16384);
        chk("trainer_pending", 64'(exp_q.size()), 64'd0);

        // downloading dropped after 1000 PRG bytes.
        wr_cnt = 0;
        start_load();
        send_header(8'd1, 8'd1, 8'h00, 8'h1A);
        for (int i = 0; i < 1000; i++) send_byte(8'($urandom), 1'b1, 22'(i), 1'b0);
        stop_load();
        chk("short_err", 64'({busy, error, err_code}), 64'b0111);
        send_byte(8'h12, 1'b0, 22'd0, 1'b0);
        cyc(1);
        chk("short_wr_cnt", 64'(wr_cnt), 64'd1000);
        chk("short_pending", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
